// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selection tables, per-round
// shift counts, schedule state encoding and the 28-bit half rotations.
package des_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Table entries are FIPS bit numbers (1-based, bit 1 = leftmost).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Index 0 is the MSB, so a left shift moves bits toward FIPS bit 1.
    function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
        return (x << n) | (x >> (5'd28 - 5'(n)));
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
        return (x >> n) | (x << (5'd28 - 5'(n)));
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 permuted choice: selects the 48 round-key bits from the 56-bit C||D.
module des_pc2
    import des_pkg::*;
(
    input  logic [0:55] i_cd,
    output logic [0:47] o_subkey
);

    for (genvar i = 0; i < 48; i++) begin : g_sel
        assign o_subkey[i] = i_cd[PC2[i] - 1];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads one key through PC-1 and streams the
// sixteen PC-2 subkeys, forward for encryption or reversed for decryption.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [0:63] key,
    input  logic        decrypt,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [0:47] subkey,
    output logic [3:0]  subkey_round
);

    state_t      r_state, w_state_nxt;
    logic [0:27] r_c, r_d, w_c_nxt, w_d_nxt;
    logic [3:0]  r_rnd, w_rnd_nxt;
    logic        r_dec, w_dec_nxt;
    logic [0:55] w_pc1;
    logic [4:0]  w_enc_idx, w_dec_idx;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign w_pc1[i] = key[PC1[i] - 1];
    end

    // Shift that takes the current output round to the next one in each direction.
    assign w_enc_idx = {1'b0, r_rnd} + 5'd2;
    assign w_dec_idx = 5'd16 - {1'b0, r_rnd};

    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_rnd_nxt   = r_rnd;
        w_dec_nxt   = r_dec;
        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_state_nxt = RUN;
                    w_rnd_nxt   = 4'd0;
                    w_dec_nxt   = decrypt;
                    if (decrypt) begin
                        w_c_nxt = w_pc1[0:27];
                        w_d_nxt = w_pc1[28:55];
                    end else begin
                        w_c_nxt = rotl28(w_pc1[0:27], 2'd1);
                        w_d_nxt = rotl28(w_pc1[28:55], 2'd1);
                    end
                end
            end
            RUN: begin
                if (subkey_ready) begin
                    if (r_rnd == 4'd15) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_rnd_nxt = r_rnd + 4'd1;
                        if (r_dec) begin
                            w_c_nxt = rotr28(r_c, SHIFT[w_dec_idx]);
                            w_d_nxt = rotr28(r_d, SHIFT[w_dec_idx]);
                        end else begin
                            w_c_nxt = rotl28(r_c, SHIFT[w_enc_idx]);
                            w_d_nxt = rotl28(r_d, SHIFT[w_enc_idx]);
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_rnd   <= '0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_rnd   <= w_rnd_nxt;
            r_dec   <= w_dec_nxt;
        end
    end

    assign key_ready    = (r_state == IDLE);
    assign subkey_valid = (r_state == RUN);
    assign subkey_round = r_rnd;

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key schedule. Accepts one 64-bit key, applies PC-1, then emits the sixteen 48-bit round subkeys one per accepted transfer over a valid/ready stream. The subkeys come out in K1..K16 order for encryption and K16..K1 for decryption. It sits directly upstream of the round datapath and supplies the `key` operand of each Feistel round.

## Interface

Parameters:
- none; all tables are fixed by FIPS 46-3.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: a key is offered.
- `key_ready` out 1: the block is idle and can take a key.
- `key` in [0:63]: DES key, bit 0 = FIPS bit 1; parity bits 7,15,…,63 are ignored.
- `decrypt` in 1: sampled with `key`. 0 selects K1..K16 order; 1 selects K16..K1.
- `subkey_valid` out 1: `subkey` is valid.
- `subkey_ready` in 1: the round stage consumes the subkey.
- `subkey` out [0:47]: current round subkey, PC-2 output, bit 0 = FIPS bit 1.
- `subkey_round` out 4: transfer index 0..15 within the current key.

## Operation

- States:
  - IDLE: `key_ready`=1, `subkey_valid`=0.
  - RUN: `key_ready`=0, `subkey_valid`=1.
- Registers:
  - C, D: 28 bits each.
  - `rnd`: 4 bits.
  - `dec`: 1 bit.
- `subkey` = PC-2(C‖D), combinational from registers only; no input-to-output paths.
- Shift table SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Load: IDLE and `key_valid`&`key_ready` → RUN, `rnd`←0, `dec`←`decrypt`.
  - Encrypt: C‖D ← rotl28 of each PC-1 half by 1, so the first output is K1.
  - Decrypt: C‖D ← PC-1 halves unrotated, so the first output is K16 (C16=C0, since the total shift is 28).
- Advance on `subkey_valid`&`subkey_ready` with `rnd`<15: `rnd`←`rnd`+1.
  - Encrypt: C and D each rotate left by SHIFT[`rnd`+2].
  - Decrypt: C and D each rotate right by SHIFT[16−`rnd`].
- Final: transfer with `rnd`=15 → IDLE. C, D and `rnd` are held; they are don't-care in IDLE.
- Stall: `subkey_valid`=1 with `subkey_ready`=0 holds `subkey`, `subkey_round` and `subkey_valid` stable.
- `key_valid` during RUN is ignored and the key is not queued. The upstream holds it until `key_ready`.
- Rotations are modulo 28 within each half. No bit ever crosses between C and D.

## Timing

- Reset values:
  - `key_ready`=1, `subkey_valid`=0, `subkey_round`=0.
  - C=D=0, so `subkey`=0.
  - `dec`=0, state IDLE.
- Load latency: key accepted at edge N → `subkey_valid`=1, round 0, from edge N (visible in cycle N+1).
- Throughput: with `subkey_ready` held at 1, the 16 subkeys appear on 16 consecutive cycles.
- `key_ready` returns 1 in the cycle after the round-15 transfer. Minimum period is 17 cycles per key.
- Back-to-back: a key offered while `key_ready`=1 in that cycle is accepted. There is no dead cycle beyond the single IDLE cycle.
- Reset mid-RUN: immediate return to the reset values. The partial sequence is discarded and no further subkeys are presented.
- `subkey_ready` may toggle arbitrarily. Exactly 16 transfers occur per accepted key, in order, with none skipped or duplicated.

## Structure

- `des_pkg` holds:
  - the PC1 (56 entries) and PC2 (48 entries) index constants;
  - the SHIFT[1..16] constant;
  - the state enum (IDLE, RUN);
  - the functions `rotl28` and `rotr28`.
- One sub-module, `des_pc2`: combinational 56→48 selection. It is reused later by any unrolled schedule.
- PC-1 is inline in `des_key_schedule` because it is used only at load.

## Test plan

- Key 0x133457799BBCDFF1, `decrypt`=0, ready held 1:
  - round 0 = 0x1B02EFFC7072;
  - round 1 = 0x79AED9DBC9E5;
  - round 15 = 0xCB3D8B0E17F5;
  - `key_ready`=1 one cycle after round 15.
- Same key, `decrypt`=1: round 0 = 0xCB3D8B0E17F5, round 14 = 0x79AED9DBC9E5, round 15 = 0x1B02EFFC7072. The whole sequence equals the encrypt sequence reversed.
- Key 0x0101010101010101 (parity bits only) and key 0x0: all 16 subkeys = 0 in both modes.
- Random `subkey_ready` stalls (≥30% low) on the first key: outputs are stable during stalls, exactly 16 transfers occur, and the values match the unstalled run. `key_valid` pulsed during RUN is ignored.
- Assert `rst_n`=0 after round 7: `subkey_valid` drops at once and `key_ready`=1. A new key then loads with round 0 correct.
- Two keys offered back-to-back: 34 cycles total with ready=1, and the second key's `dec` is independent of the first.
